dm_port_arbiter: RTL

// Shares the single data-BRAM port between the pipeline MEM stage (CPU) and a DMA/loader requester.

---
 rtl/dm_port_arbiter_pkg.sv | 27 ++
 rtl/dm_port_arbiter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/dm_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter: FSM state encodings and
// owner codes used by the output mux and the read-return steering.
package dm_port_arbiter_pkg;

    typedef enum logic [1:0] {
        CPU_PRI    = 2'd0,
        DMA_FORCED = 2'd1,
        DMA_BURST  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

    // Plain CPU-first choice, shared by CPU_PRI and by a burst that ends.
    function automatic owner_t pri_owner(input logic cpu_req, input logic dma_req);
        if (cpu_req)
            return OWN_CPU;
        else if (dma_req)
            return OWN_DMA;
        else
            return OWN_NONE;
    endfunction

endpackage

// File: rtl/dm_port_arbiter.sv
// Single-port data-BRAM arbiter between the MEM stage (priority) and a DMA
// requester, with starvation forcing and bounded locked DMA bursts.
module dm_port_arbiter
    import dm_port_arbiter_pkg::*;
#(
    parameter int ADDR_W        = 12,
    parameter int DATA_W        = 32,
    parameter int STARVE_LIMIT  = 8,
    parameter int DMA_MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [3:0]        cpu_be,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wd,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [3:0]        dma_be,
    input  logic              dma_lock,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wd,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] bram_A,
    output logic              bram_we,
    output logic [3:0]        bram_be,
    output logic [DATA_W-1:0] bram_D,
    input  logic [DATA_W-1:0] bram_Dout,
    output state_t            fsm_state
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int BW = $clog2(DMA_MAX_BURST + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_LIMIT - 1);
    localparam logic [BW-1:0] BURST_TOP  = BW'(DMA_MAX_BURST);

    state_t        state;
    owner_t        owner;
    owner_t        rd_owner;
    logic [SW-1:0] starve_cnt;
    logic [BW-1:0] burst_cnt;
    logic          burst_go;

    // Handshake: a request is a level held until its grant; the CPU sees the
    // grant as !cpu_stall, the DMA as dma_gnt, both in the same cycle, and
    // read data follows one cycle after the granted read.
    always_comb begin
        owner    = OWN_NONE;
        burst_go = 1'b0;
        if (rst) begin
            case (state)
                DMA_FORCED: owner = dma_req ? OWN_DMA : (cpu_req ? OWN_CPU : OWN_NONE);
                DMA_BURST: begin
                    if (dma_req && dma_lock && (burst_cnt < BURST_TOP)) begin
                        owner    = OWN_DMA;
                        burst_go = 1'b1;
                    end else begin
                        owner = pri_owner(cpu_req, dma_req);
                    end
                end
                default: owner = pri_owner(cpu_req, dma_req);
            endcase
        end
    end

    assign cpu_stall = rst && cpu_req && (owner != OWN_CPU);
    assign dma_gnt   = dma_req && (owner == OWN_DMA);

    always_comb begin
        bram_A  = cpu_addr;
        bram_we = 1'b0;
        bram_be = 4'h0;
        bram_D  = cpu_wd;
        case (owner)
            OWN_CPU: begin
                bram_we = cpu_we;
                bram_be = cpu_be;
            end
            OWN_DMA: begin
                bram_A  = dma_addr;
                bram_we = dma_we;
                bram_be = dma_be;
                bram_D  = dma_wd;
            end
            default: ;
        endcase
    end

    // Both requesters see the same BRAM output; rd_owner records who it is for.
    assign cpu_rdata = bram_Dout;
    assign dma_rdata = bram_Dout;
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= CPU_PRI;
            starve_cnt <= '0;
            burst_cnt  <= '0;
            dma_rvalid <= 1'b0;
            rd_owner   <= OWN_CPU;
        end else begin
            rd_owner   <= owner;
            dma_rvalid <= dma_gnt && !dma_we;

            if (dma_gnt || !dma_req || state == DMA_FORCED)
                starve_cnt <= '0;
            else if (starve_cnt != STARVE_TOP)
                starve_cnt <= starve_cnt + 1'b1;

            case (state)
                CPU_PRI: begin
                    if (dma_gnt && dma_lock) begin
                        state     <= DMA_BURST;
                        burst_cnt <= BW'(1);
                    end else if (cpu_req && dma_req && starve_cnt == STARVE_TOP) begin
                        state <= DMA_FORCED;
                    end
                end
                DMA_FORCED: begin
                    if (dma_gnt && dma_lock) begin
                        state     <= DMA_BURST;
                        burst_cnt <= BW'(1);
                    end else begin
                        state <= CPU_PRI;
                    end
                end
                DMA_BURST: begin
                    if (burst_go) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end else begin
                        state     <= CPU_PRI;
                        burst_cnt <= '0;
                    end
                end
                default: begin
                    state     <= CPU_PRI;
                    burst_cnt <= '0;
                end
            endcase
        end
    end

endmodule
